// File: rtl/calc_display_driver_if.sv
// ---------------------------------------------------------------------------
// calc_display_driver_if
//
// Purpose : bundles the calculator-side inputs and the 4-digit seven-segment
//           outputs of calc_display_driver into a single port.
//
// Signals :
//   i_Result [7:0]  unsigned magnitude coming from the calculator stage
//   i_Neg           sign of the result, 1 = negative
//   o_Seg    [6:0]  segment pattern {g,f,e,d,c,b,a}, active-low
//   o_An     [3:0]  digit enables, active-low one-hot, bit0 = rightmost digit
//   o_Busy          high while a binary-to-BCD conversion is running
//
// Modports:
//   master - the side that produces the result and watches the display
//   slave  - the display driver itself
// ---------------------------------------------------------------------------
interface calc_display_driver_if;
  logic [7:0] i_Result;
  logic       i_Neg;
  logic [6:0] o_Seg;
  logic [3:0] o_An;
  logic       o_Busy;

  modport master (
    output i_Result,
    output i_Neg,
    input  o_Seg,
    input  o_An,
    input  o_Busy
  );

  modport slave (
    input  i_Result,
    input  i_Neg,
    output o_Seg,
    output o_An,
    output o_Busy
  );
endinterface

// File: rtl/calc_display_driver.sv
// ---------------------------------------------------------------------------
// calc_display_driver
//
// Purpose : shows a signed 8-bit calculator result on a multiplexed 4-digit
//           common-anode seven-segment display. The magnitude is converted to
//           BCD with a sequential double-dabble (one shift per clock) and the
//           finished digits are copied into display registers in one step, so
//           the display never shows a half-converted number. The leftmost digit
//           shows '-' for negative results.
//
// Ports   :
//   i_Clk        rising-edge clock
//   i_Rst_n      asynchronous active-low reset
//   bus (slave)  i_Result, i_Neg in; o_Seg, o_An, o_Busy out (all registered)
//
// Parameters:
//   REFRESH_DIV  clock cycles each digit stays enabled (minimum 2)
//
// Build options:
//   LEADING_ZERO_BLANK_EN  when defined, a zero hundreds digit is blanked and
//                          the tens digit is blanked when hundreds and tens
//                          are both zero. Ones and sign digits are unaffected.
// ---------------------------------------------------------------------------
module calc_display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  calc_display_driver_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  // Conversion path
  state_t      state_q, state_d;
  logic [8:0]  held_q, held_d;
  logic [19:0] shift_q, shift_d;
  logic [2:0]  step_q, step_d;
  logic        busy_q, busy_d;

  // Display registers (only ever written with a complete conversion)
  logic        sign_q, sign_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;

  // Scan path
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic             blank_hund;
  logic             blank_tens;

  // One double-dabble step on the {hundreds,tens,ones,binary} register:
  // correct every BCD nibble that would overflow past 9 after doubling,
  // then shift the whole register left by one bit.
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_pattern(input logic [3:0] bcd);
    logic [6:0] p;
    case (bcd)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

  // Conversion FSM next-state logic. A new conversion starts only from IDLE
  // and only when the inputs differ from the value last latched, so input
  // activity during a conversion is picked up on the first IDLE edge after it.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    shift_d = shift_q;
    step_d  = step_q;
    busy_d  = busy_q;
    sign_d  = sign_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;

    case (state_q)
      IDLE: begin
        if ({bus.i_Neg, bus.i_Result} != held_q) begin
          held_d  = {bus.i_Neg, bus.i_Result};
          shift_d = {12'd0, bus.i_Result};
          step_d  = 3'd0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end

      CONV: begin
        shift_d = dabble_step(shift_q);
        step_d  = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        // Sign comes from the held copy, not the live input, so it always
        // matches the magnitude that was converted.
        sign_d  = held_q[8];
        hund_d  = shift_q[19:16];
        tens_d  = shift_q[15:12];
        ones_d  = shift_q[11:8];
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Leading-zero suppression decision for the two upper numeric digits.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    blank_hund = (hund_q == 4'd0);
    blank_tens = (hund_q == 4'd0) && (tens_q == 4'd0);
`else
    blank_hund = 1'b0;
    blank_tens = 1'b0;
`endif
  end

  // Display multiplexer. The refresh counter runs independently of the
  // conversion FSM; the anode and segment registers follow the digit index
  // one edge later so that both always change together.
  always_comb begin
    scan_cnt_d  = scan_cnt_q + CNT_W'(1);
    digit_idx_d = digit_idx_q;
    if (scan_cnt_q == CNT_MAX) begin
      scan_cnt_d  = '0;
      digit_idx_d = digit_idx_q + 2'd1;
    end

    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    case (digit_idx_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = seg_pattern(ones_q);
      end
      2'd1: begin
        an_d  = 4'b1101;
        seg_d = blank_tens ? SEG_BLANK : seg_pattern(tens_q);
      end
      2'd2: begin
        an_d  = 4'b1011;
        seg_d = blank_hund ? SEG_BLANK : seg_pattern(hund_q);
      end
      default: begin
        an_d  = 4'b0111;
        seg_d = sign_q ? SEG_MINUS : SEG_BLANK;
      end
    endcase
  end

  // State registers. Reset aborts any conversion in flight and forces the
  // outputs dark without waiting for a clock.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= IDLE;
      held_q      <= 9'd0;
      shift_q     <= 20'd0;
      step_q      <= 3'd0;
      busy_q      <= 1'b0;
      sign_q      <= 1'b0;
      hund_q      <= 4'd0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
      an_q        <= 4'b1111;
      seg_q       <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      shift_q     <= shift_d;
      step_q      <= step_d;
      busy_q      <= busy_d;
      sign_q      <= sign_d;
      hund_q      <= hund_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign bus.o_Seg  = seg_q;
  assign bus.o_An   = an_q;
  assign bus.o_Busy = busy_q;

endmodule

// File: tb/tb_calc_display_driver.sv
// ---------------------------------------------------------------------------
// tb_calc_display_driver
//
// Purpose : self-checking bench for calc_display_driver with REFRESH_DIV=4.
//           A cycle-level reference model works from plain arithmetic (a
//           countdown for the busy window, /100 and %10 for the digits) and a
//           compare process checks every output on every falling edge.
//           Directed tests add literal expectations for the key scenarios.
//           Works with or without LEADING_ZERO_BLANK_EN defined.
// ---------------------------------------------------------------------------
module tb_calc_display_driver;

  localparam int RD = 4;

  logic clk;
  logic rst_n;
  int   assertCount = 0;
  int   failCount   = 0;
  bit   compareEn   = 1'b0;

  calc_display_driver_if bus ();

  calc_display_driver #(
    .REFRESH_DIV (RD)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Drive new calculator inputs just after a falling edge.
  task automatic applyStimulus(input logic neg, input logic [7:0] res);
    @(negedge clk);
    bus.i_Neg    = neg;
    bus.i_Result = res;
  endtask

  function automatic logic [6:0] digitPattern(input int d);
    logic [6:0] p;
    case (d)
      0: p = 7'b1000000;
      1: p = 7'b1111001;
      2: p = 7'b0100100;
      3: p = 7'b0110000;
      4: p = 7'b0011001;
      5: p = 7'b0010010;
      6: p = 7'b0000010;
      7: p = 7'b1111000;
      8: p = 7'b0000000;
      default: p = 7'b0010000;
    endcase
    return p;
  endfunction

  // What a given digit position must show for a signed value.
  function automatic logic [6:0] expectSeg(input int pos, input logic sign, input int value);
    logic [6:0] p;
    bit lzb;
`ifdef LEADING_ZERO_BLANK_EN
    lzb = 1'b1;
`else
    lzb = 1'b0;
`endif
    case (pos)
      0: p = digitPattern(value % 10);
      1: p = (lzb && value < 10) ? 7'b1111111 : digitPattern((value / 10) % 10);
      2: p = (lzb && value < 100) ? 7'b1111111 : digitPattern(value / 100);
      default: p = sign ? 7'b0111111 : 7'b1111111;
    endcase
    return p;
  endfunction

  // Reference model state (post-edge values).
  logic [8:0] mHeld      = 9'd0;
  int         mRemaining = 0;
  logic       mSign      = 1'b0;
  int         mValue     = 0;
  int         mTick      = 0;
  int         mDigit     = 0;
  logic [3:0] mAn        = 4'b1111;
  logic [6:0] mSeg       = 7'b1111111;
  logic       mBusy      = 1'b0;

  // Reference model: a conversion is a 9-edge busy window after the edge
  // that notices a new value; the display takes the latched value when the
  // window closes. Outputs show the digit selected before each edge.
  always @(posedge clk or negedge rst_n) begin
    logic [3:0] one;
    one = 4'b0001;
    if (!rst_n) begin
      mHeld = 9'd0; mRemaining = 0; mSign = 1'b0; mValue = 0;
      mTick = 0; mDigit = 0; mAn = 4'b1111; mSeg = 7'b1111111; mBusy = 1'b0;
    end else begin
      mAn  = ~(one << mDigit);
      mSeg = expectSeg(mDigit, mSign, mValue);
      if (mTick == RD - 1) begin
        mTick  = 0;
        mDigit = (mDigit + 1) % 4;
      end else begin
        mTick++;
      end
      if (mRemaining == 0) begin
        if ({bus.i_Neg, bus.i_Result} != mHeld) begin
          mHeld      = {bus.i_Neg, bus.i_Result};
          mRemaining = 9;
          mBusy      = 1'b1;
        end
      end else begin
        mRemaining--;
        if (mRemaining == 0) begin
          mValue = int'(mHeld[7:0]);
          mSign  = mHeld[8];
          mBusy  = 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (compareEn) begin
      checkOutput("model o_Busy", 32'(bus.o_Busy), 32'(mBusy));
      checkOutput("model o_An",   32'(bus.o_An),   32'(mAn));
      checkOutput("model o_Seg",  32'(bus.o_Seg),  32'(mSeg));
    end
  end

  // Wait (bounded) until o_Busy reaches the given level.
  task automatic waitBusy(input logic level, input int maxCycles, input string what);
    int n;
    n = 0;
    while (bus.o_Busy !== level && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(what, 32'(bus.o_Busy === level), 32'd1);
  endtask

  // Wait (bounded) for a digit to be enabled and return its segments.
  task automatic captureDigit(input int pos, output logic [6:0] seg);
    logic [3:0] one;
    logic [3:0] an;
    int n;
    one = 4'b0001;
    an  = ~(one << pos);
    n   = 0;
    while (bus.o_An !== an && n < 4 * RD + 4) begin
      @(negedge clk);
      n++;
    end
    checkOutput("digit enable seen", 32'(bus.o_An), 32'(an));
    seg = bus.o_Seg;
  endtask

  task automatic waitDone();
    waitBusy(1'b0, 30, "conversion finishes");
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [6:0] seg;
    logic [6:0] zeroUpper;
    logic [3:0] anSeq [4];
    int busyCycles;

`ifdef LEADING_ZERO_BLANK_EN
    zeroUpper = 7'b1111111;
`else
    zeroUpper = 7'b1000000;
`endif
    anSeq[0] = 4'b1110; anSeq[1] = 4'b1101; anSeq[2] = 4'b1011; anSeq[3] = 4'b0111;

    bus.i_Result = 8'd0;
    bus.i_Neg    = 1'b0;
    rst_n        = 1'b1;

    // Reset asserted between edges: outputs must go dark at once.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset o_An",   32'(bus.o_An),   32'h0000000F);
    checkOutput("reset o_Seg",  32'(bus.o_Seg),  32'h0000007F);
    checkOutput("reset o_Busy", 32'(bus.o_Busy), 32'd0);
    compareEn = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 255 positive: busy for exactly nine cycles, then 255 on display.
    applyStimulus(1'b0, 8'd255);
    waitBusy(1'b1, 4, "busy rises for 255");
    busyCycles = 0;
    while (bus.o_Busy === 1'b1 && busyCycles < 20) begin
      busyCycles++;
      @(negedge clk);
    end
    checkOutput("busy length 255", 32'(busyCycles), 32'd9);
    @(negedge clk);
    captureDigit(0, seg); checkOutput("255 digit0", 32'(seg), 32'h12);
    captureDigit(1, seg); checkOutput("255 digit1", 32'(seg), 32'h12);
    captureDigit(2, seg); checkOutput("255 digit2", 32'(seg), 32'h24);
    captureDigit(3, seg); checkOutput("255 digit3", 32'(seg), 32'h7F);

    // -7: minus sign, leading digits depend on the blanking option.
    applyStimulus(1'b1, 8'd7);
    waitBusy(1'b1, 4, "busy rises for -7");
    waitDone();
    captureDigit(0, seg); checkOutput("-7 digit0", 32'(seg), 32'h78);
    captureDigit(1, seg); checkOutput("-7 digit1", 32'(seg), 32'(zeroUpper));
    captureDigit(2, seg); checkOutput("-7 digit2", 32'(seg), 32'(zeroUpper));
    captureDigit(3, seg); checkOutput("-7 digit3", 32'(seg), 32'h3F);

    // Input changes during a conversion: 12 finishes, then 34 follows.
    applyStimulus(1'b0, 8'd12);
    waitBusy(1'b1, 4, "busy rises for 12");
    @(negedge clk);
    applyStimulus(1'b0, 8'd34);
    waitBusy(1'b0, 20, "first conversion ends");
    waitBusy(1'b1, 3, "second conversion starts");
    waitDone();
    captureDigit(0, seg); checkOutput("34 digit0", 32'(seg), 32'h19);
    captureDigit(1, seg); checkOutput("34 digit1", 32'(seg), 32'h30);
    captureDigit(2, seg); checkOutput("34 digit2", 32'(seg), 32'(zeroUpper));

    // Scan order and dwell: each enable held RD cycles, then wrap.
    begin
      int n;
      logic [3:0] prev;
      n    = 0;
      prev = bus.o_An;
      @(negedge clk);
      while (!(bus.o_An === 4'b1110 && prev !== 4'b1110) && n < 40) begin
        prev = bus.o_An;
        @(negedge clk);
        n++;
      end
      for (int i = 0; i < 4 * RD; i++) begin
        checkOutput("scan sequence", 32'(bus.o_An), 32'(anSeq[i / RD]));
        @(negedge clk);
      end
      checkOutput("scan wrap", 32'(bus.o_An), 32'h0000000E);
    end

    // Reset in the middle of a conversion: display returns to 000.
    applyStimulus(1'b0, 8'd99);
    waitBusy(1'b1, 4, "busy rises for 99");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid-conv reset o_Busy", 32'(bus.o_Busy), 32'd0);
    checkOutput("mid-conv reset o_An",   32'(bus.o_An),   32'h0000000F);
    bus.i_Result = 8'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    captureDigit(0, seg); checkOutput("after abort digit0", 32'(seg), 32'h40);
    captureDigit(1, seg); checkOutput("after abort digit1", 32'(seg), 32'(zeroUpper));
    captureDigit(2, seg); checkOutput("after abort digit2", 32'(seg), 32'(zeroUpper));
    checkOutput("after abort o_Busy", 32'(bus.o_Busy), 32'd0);

    // Nonzero input across reset release starts on the first edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.i_Result = 8'd5;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("start after release", 32'(bus.o_Busy), 32'd1);
    waitDone();
    captureDigit(0, seg); checkOutput("5 digit0", 32'(seg), 32'h12);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
